serial_mag_comparator: RTL and testbench
========================================

Name: serial_mag_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Time-shares one 2-bit comparator slice, stepping MSB-first one 2-bit digit per cycle, with early termination on the first unequal digit.
- Sits between a requester (valid/ready start channel) and a consumer (valid/ready result channel).
- Used where area matters more than latency, e.g. sorting/threshold units in the datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration-time assertion).
- NDIG, WIDTH/2, number of 2-bit digits (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- start_valid  input  1  requester presents operands.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- res_valid  output  1  result flags valid.
- res_ready  input  1  consumer accepts result.
- a_gt_b  output  1  A > B.
- a_eq_b  output  1  A == B.
- a_lt_b  output  1  A < B.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; a_gt_b=a_eq_b=a_lt_b=0; res_valid=0; busy=0; start_ready=1 after reset.
  - Reset mid-operation abandons the comparison; no result is ever produced for it.
- FSM states: IDLE, COMPARE, DONE. Outputs decode from state: start_ready=(IDLE), res_valid=(DONE), busy=!(IDLE).
- IDLE:
  - On start_valid&&start_ready: register a and b, set digit index idx=NDIG-1, go to COMPARE.
  - After acceptance, a and b are don't-care until the next handshake.
- COMPARE (one digit per cycle): slice compares a_r[2*idx+1:2*idx] with b_r[2*idx+1:2*idx].
  - Slice gt: latch GT, go to DONE.
  - Slice lt: latch LT, go to DONE.
  - Slice eq and idx==0: latch EQ, go to DONE.
  - Slice eq and idx>0: idx--, stay in COMPARE.
- Index rules:
  - idx is $clog2(NDIG) bits wide, min 1.
  - idx never wraps; the idx==0 check has priority over the decrement.
- DONE:
  - res_valid=1. Exactly one of the three flags is 1, held stable until res_ready.
  - On res_ready: clear all flags to 0 and go to IDLE.
  - start_ready is 0 in DONE, so a new start cannot be accepted in the same cycle as res_ready; earliest next accept is the following cycle.
- Flags are 0 whenever res_valid=0.
- Latency from start handshake edge to first res_valid cycle = k+1 cycles, where k = digits examined (1..NDIG).
  - Equal operands give NDIG+1.
  - Unequal operands give MSB-difference digit position + 1.
- Back-pressure: res_ready held low keeps DONE indefinitely; the result must not change.
- start_valid asserted while busy is ignored (no capture, no error).

Decomposition:
- Package cmp_pkg:
  - typedef enum logic [1:0] cmp_state_e {IDLE, COMPARE, DONE}.
  - typedef enum logic [1:0] cmp_res_e {RES_NONE, RES_GT, RES_EQ, RES_LT}.
  - localparam DIGIT_W=2.
- Sub-module cmp_digit_slice: purely combinational 2-bit comparator (x, y -> gt, eq, lt). Instantiated once and driven by the indexed digit mux.
- Controller FSM, operand registers, idx counter and result register live in serial_mag_comparator.

Test Plan:
- Reset mid-op: accept a=8'hF0, b=8'h0F; assert rst_n=0 on the next cycle -> res_valid never rises, start_ready=1 and flags=0 after rst_n returns high.
- MSB difference, WIDTH=8: a=8'hC0, b=8'h40 -> res_valid 2 cycles after the accept edge, a_gt_b=1, others 0.
- Equal operands: a=b=8'hA5 -> res_valid exactly 5 cycles after accept (NDIG=4), a_eq_b=1.
- LSB-digit difference: a=8'h12, b=8'h13 -> a_lt_b=1 after 5 cycles; also covers idx reaching 0 without wrap.
- Back-pressure and ignored start: hold res_ready=0 for 10 cycles while start_valid=1 with a=8'h00 -> flags stable, start_ready=0, no capture. Then res_ready=1 -> IDLE next cycle, and the new operand pair is accepted one cycle later.
- Parameter sweep with WIDTH=2 and WIDTH=16: random pairs checked against a reference (A>B, A==B, A<B) -> exactly one flag set; latency matches the MSB-difference rule.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

    // Latched comparison outcome; RES_NONE whenever no result is being presented
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_LT   = 2'd3
    } cmp_res_e;

    // Width of one comparator digit
    localparam int DIGIT_W = 2;

endpackage

// File: rtl/cmp_digit_slice.sv
// Purely combinational 2-bit unsigned comparator slice.
module cmp_digit_slice
    import cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               gt,
    output logic               eq,
    output logic               lt
);

    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks the operands MSB-first,
// one 2-bit digit per cycle, and stops on the first unequal digit.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             busy
);

    localparam int NDIG  = WIDTH / 2;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NDIG - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_mag_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    cmp_state_e          state_q, state_d;
    cmp_res_e            res_q,   res_d;
    logic [WIDTH-1:0]    a_q,     a_d;
    logic [WIDTH-1:0]    b_q,     b_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;

    logic [DIGIT_W-1:0]  dig_a_s;
    logic [DIGIT_W-1:0]  dig_b_s;
    logic                slice_gt_s;
    logic                slice_eq_s;
    logic                slice_lt_s;

    // Select the digit currently addressed by idx from both operand registers
    always_comb begin
        dig_a_s = '0;
        dig_b_s = '0;
        for (int i = 0; i < NDIG; i++) begin
            dig_a_s = (idx_q == IDX_W'(i)) ? a_q[i*DIGIT_W +: DIGIT_W] : dig_a_s;
            dig_b_s = (idx_q == IDX_W'(i)) ? b_q[i*DIGIT_W +: DIGIT_W] : dig_b_s;
        end
    end

    cmp_digit_slice u_slice (
        .x  (dig_a_s),
        .y  (dig_b_s),
        .gt (slice_gt_s),
        .eq (slice_eq_s),
        .lt (slice_lt_s)
    );

    // Next-state, operand capture, digit stepping and result latching
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                // start_ready is high in IDLE, so start_valid alone completes the handshake
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MSB;
                    res_d   = RES_NONE;
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (slice_gt_s) begin
                    res_d   = RES_GT;
                    state_d = DONE;
                end else if (slice_lt_s) begin
                    res_d   = RES_LT;
                    state_d = DONE;
                end else if (slice_eq_s && (idx_q == '0)) begin
                    // Last digit checked before any decrement, so idx never wraps
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = COMPARE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_d   = RES_NONE;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                res_d   = RES_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, index and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= RES_NONE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake and status decode straight from the state register
    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);

    // Flags are qualified by DONE so they can never show outside a valid result
    assign a_gt_b = (state_q == DONE) && (res_q == RES_GT);
    assign a_eq_b = (state_q == DONE) && (res_q == RES_EQ);
    assign a_lt_b = (state_q == DONE) && (res_q == RES_LT);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: 8-bit instance with hand-computed
// expectations, plus 2-bit and 16-bit instances checked against a small model.
module tb_serial_mag_comparator;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        res_ready;
    logic [15:0] a_s;
    logic [15:0] b_s;

    logic sr2, rv2, gt2, eq2, lt2, busy2;
    logic sr8, rv8, gt8, eq8, lt8, busy8;
    logic sr16, rv16, gt16, eq16, lt16, busy16;

    int n_checks;
    int n_fail;

    serial_mag_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr2),
        .a(a_s[1:0]), .b(b_s[1:0]), .res_valid(rv2), .res_ready(res_ready),
        .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2), .busy(busy2)
    );

    serial_mag_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr8),
        .a(a_s[7:0]), .b(b_s[7:0]), .res_valid(rv8), .res_ready(res_ready),
        .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8), .busy(busy8)
    );

    serial_mag_comparator #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr16),
        .a(a_s), .b(b_s), .res_valid(rv16), .res_ready(res_ready),
        .a_gt_b(gt16), .a_eq_b(eq16), .a_lt_b(lt16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result as {gt, eq, lt} for operands truncated to w bits
    function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b, input int w);
        logic [15:0] m;
        logic [15:0] am;
        logic [15:0] bm;
        m  = (w >= 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        am = a & m;
        bm = b & m;
        if (am > bm)       return 3'b100;
        else if (am == bm) return 3'b010;
        else               return 3'b001;
    endfunction

    // Reference latency: digits examined MSB-first up to the first difference, plus one
    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input int w);
        int ndig;
        ndig = w / 2;
        for (int d = ndig - 1; d >= 0; d--) begin
            if (a[2*d +: 2] != b[2*d +: 2]) return ndig - d + 1;
        end
        return ndig + 1;
    endfunction

    // Release every pending result and wait (bounded) until all instances are idle
    task automatic drain();
        res_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (sr2 && sr8 && sr16) break;
        end
        res_ready = 1'b0;
        check("drain_idle", 32'({sr2, sr8, sr16, rv2, rv8, rv16, busy2, busy8, busy16}), 32'b111_000_000);
        check("drain_flags", 32'({gt2, eq2, lt2, gt8, eq8, lt8, gt16, eq16, lt16}), 32'd0);
    endtask

    // One start handshake on all instances; 8-bit expectations come from the caller
    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] exp8, input int lat8_exp);
        int l2, l8, l16;
        logic [2:0] f2, f8, f16;
        l2 = 0; l8 = 0; l16 = 0;
        f2 = 3'b000; f8 = 3'b000; f16 = 3'b000;
        check({tag, "_ready"}, 32'({sr2, sr8, sr16}), 32'b111);
        a_s = a;
        b_s = b;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        for (int n = 2; n <= 30; n++) begin
            @(posedge clk); #1;
            if (rv2 && (l2 == 0))   begin l2 = n;  f2 = {gt2, eq2, lt2};    end
            if (rv8 && (l8 == 0))   begin l8 = n;  f8 = {gt8, eq8, lt8};    end
            if (rv16 && (l16 == 0)) begin l16 = n; f16 = {gt16, eq16, lt16}; end
            if ((l2 != 0) && (l8 != 0) && (l16 != 0)) break;
        end
        check({tag, "_lat8"},   32'(l8),  32'(lat8_exp));
        check({tag, "_flags8"}, 32'(f8),  32'(exp8));
        check({tag, "_lat2"},   32'(l2),  32'(ref_lat(a, b, 2)));
        check({tag, "_flags2"}, 32'(f2),  32'(ref_flags(a, b, 2)));
        check({tag, "_lat16"},  32'(l16), 32'(ref_lat(a, b, 16)));
        check({tag, "_flags16"}, 32'(f16), 32'(ref_flags(a, b, 16)));
        drain();
    endtask

    initial begin
        logic        seen_valid;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a_s         = 16'h0000;
        b_s         = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", 32'({sr2, sr8, sr16}), 32'b111);
        check("rst_valid_busy", 32'({rv2, rv8, rv16, busy2, busy8, busy16}), 32'd0);
        check("rst_flags", 32'({gt8, eq8, lt8, gt16, eq16, lt16}), 32'd0);

        // Reset in the middle of a comparison abandons it
        a_s = 16'h00F0;
        b_s = 16'h000F;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("midrst_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ready", 32'({sr8, rv8, busy8}), 32'b100);
        check("midrst_flags", 32'({gt8, eq8, lt8}), 32'd0);
        seen_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | rv2 | rv8 | rv16;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);

        // Directed 8-bit vectors
        run_txn("msb_gt", 16'h00C0, 16'h0040, 3'b100, 2);
        run_txn("equal",  16'h00A5, 16'h00A5, 3'b010, 5);
        run_txn("lsb_lt", 16'h0012, 16'h0013, 3'b001, 5);
        run_txn("dig2_gt", 16'h0034, 16'h0024, 3'b100, 3);
        run_txn("zero_eq", 16'h0000, 16'h0000, 3'b010, 5);
        run_txn("max_lt", 16'h00FE, 16'h00FF, 3'b001, 5);

        // Back-pressure: result held, start ignored while busy
        a_s = 16'h0080;
        b_s = 16'h007F;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rv8) begin lat = n; break; end
        end
        check("bp_lat8", 32'(lat), 32'd2);
        a_s = 16'h0000;
        b_s = 16'h0001;
        start_valid = 1'b1;
        res_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("bp_hold", 32'({sr8, rv8, gt8, eq8, lt8}), 32'b01_100);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_release", 32'({sr8, rv8, busy8, gt8, eq8, lt8}), 32'b100_000);
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("bp_accept_next", 32'({sr8, busy8}), 32'b01);
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rv8) begin lat = n; break; end
        end
        check("bp_new_lat8", 32'(lat), 32'd5);
        check("bp_new_flags8", 32'({gt8, eq8, lt8}), 32'b001);
        drain();

        // Random sweep; 8-bit expectations from the reference model here
        for (int i = 0; i < 18; i++) begin
            ra = 16'($urandom);
            case (i % 3)
                0:       rb = ra;
                1:       rb = ra ^ (16'd1 << $urandom_range(15, 0));
                default: rb = 16'($urandom);
            endcase
            run_txn("rand", ra, rb, ref_flags(ra, rb, 8), ref_lat(ra, rb, 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
